// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32I opcode/funct constants and the decoded bundle type
// used by the decode stage and the ALU.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_AND  = 5'd0,
        ALU_OR   = 5'd1,
        ALU_ADD  = 5'd2,
        ALU_SUB  = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLT  = 5'd5,
        ALU_SLTU = 5'd6,
        ALU_SLL  = 5'd7,
        ALU_SRL  = 5'd8,
        ALU_SRA  = 5'd9
    } alu_op_e;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;
    localparam logic [2:0] F3_BEQ     = 3'd0;
    localparam logic [2:0] F3_BNE     = 3'd1;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U
    } imm_fmt_e;

    typedef struct packed {
        alu_op_e     alu_ctrl;
        logic        alu_src_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        illegal;
    } dec_bundle_t;

    // funct3 -> ALU op for the base (funct7 = 0) register and immediate forms.
    function automatic alu_op_e f3_to_alu_op(input logic [2:0] f3);
        alu_op_e op;
        case (f3)
            F3_ADD_SUB: op = ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational RV32I immediate extraction; the opcode bits [6:0] play no part
// in any immediate, so only instr[31:7] is taken.
module rv_imm_gen
    import alu_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        imm = '0;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered RV32I ALU decode stage with valid/ready handshakes on both sides.
// Define ALU_DECODE_SKID_EN to register in_ready behind a one-entry skid buffer.
module alu_decode_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  alu_ctrl,
    output logic        alu_src_imm,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    imm_fmt_e    imm_fmt;
    logic [31:0] imm_val;
    dec_bundle_t dec_raw;
    dec_bundle_t dec_bundle;

    dec_bundle_t out_q, out_d;
    logic        out_valid_q, out_valid_d;
    logic        fire_in;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    rv_imm_gen u_imm_gen (
        .instr (instr[31:7]),
        .fmt   (imm_fmt),
        .imm   (imm_val)
    );

    always_comb begin
        dec_raw     = '0;
        imm_fmt     = IMM_NONE;
        dec_raw.rs1 = instr[19:15];
        dec_raw.rs2 = instr[24:20];
        dec_raw.rd  = instr[11:7];
        case (opcode)
            OPC_OP: begin
                dec_raw.reg_write = 1'b1;
                if (funct7 == F7_BASE)
                    dec_raw.alu_ctrl = f3_to_alu_op(funct3);
                else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB)
                    dec_raw.alu_ctrl = ALU_SUB;
                else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA)
                    dec_raw.alu_ctrl = ALU_SRA;
                else
                    dec_raw.illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                imm_fmt             = IMM_I;
                dec_raw.alu_src_imm = 1'b1;
                dec_raw.reg_write   = 1'b1;
                dec_raw.alu_ctrl    = f3_to_alu_op(funct3);
                // Shift-immediates reuse imm[11:5] as a funct7 qualifier.
                if (funct3 == F3_SLL && funct7 != F7_BASE)
                    dec_raw.illegal = 1'b1;
                if (funct3 == F3_SRL_SRA) begin
                    if (funct7 == F7_ALT)
                        dec_raw.alu_ctrl = ALU_SRA;
                    else if (funct7 != F7_BASE)
                        dec_raw.illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                imm_fmt             = IMM_I;
                dec_raw.alu_ctrl    = ALU_ADD;
                dec_raw.alu_src_imm = 1'b1;
                dec_raw.reg_write   = 1'b1;
            end
            OPC_STORE: begin
                imm_fmt             = IMM_S;
                dec_raw.alu_ctrl    = ALU_ADD;
                dec_raw.alu_src_imm = 1'b1;
            end
            OPC_BRANCH: begin
                imm_fmt          = IMM_B;
                dec_raw.alu_ctrl = ALU_SUB;
                if (funct3 != F3_BEQ && funct3 != F3_BNE)
                    dec_raw.illegal = 1'b1;
            end
            OPC_LUI: begin
                imm_fmt             = IMM_U;
                dec_raw.alu_ctrl    = ALU_ADD;
                dec_raw.alu_src_imm = 1'b1;
                dec_raw.reg_write   = 1'b1;
                dec_raw.rs1         = '0;
            end
            default: dec_raw.illegal = 1'b1;
        endcase
    end

    // Illegal encodings travel as an all-zero bundle carrying only the illegal flag.
    always_comb begin
        dec_bundle           = dec_raw;
        dec_bundle.imm       = imm_val;
        dec_bundle.reg_write = dec_raw.reg_write && (dec_raw.rd != 5'd0);
        if (dec_raw.illegal) begin
            dec_bundle         = '0;
            dec_bundle.illegal = 1'b1;
        end
    end

`ifdef ALU_DECODE_SKID_EN
    dec_bundle_t skid_q, skid_d;
    logic        skid_valid_q, skid_valid_d;
    logic        in_ready_q, in_ready_d;
    logic        drain;

    assign in_ready = in_ready_q;
    assign fire_in  = in_valid && in_ready_q;
    assign drain    = !out_valid_q || out_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (drain) begin
            // A held skid entry is older than anything on the input, so it goes first.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (fire_in) begin
                out_d       = dec_bundle;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (fire_in) begin
            skid_d       = dec_bundle;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset too, because the data outputs must read zero out of reset.
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end
`else
    assign in_ready = rst_n && (!out_valid_q || out_ready);
    assign fire_in  = in_valid && in_ready;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (fire_in) begin
            out_d       = dec_bundle;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset too, because the data outputs must read zero out of reset.
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end
`endif

    assign out_valid   = out_valid_q;
    assign alu_ctrl    = out_q.alu_ctrl;
    assign alu_src_imm = out_q.alu_src_imm;
    assign imm         = out_q.imm;
    assign rs1         = out_q.rs1;
    assign rs2         = out_q.rs2;
    assign rd          = out_q.rd;
    assign reg_write   = out_q.reg_write;
    assign illegal     = out_q.illegal;

endmodule

// File: doc/alu_decode_stage.md
ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 The block SHALL have the ports below; the clock and reset are single-clock, synchronous, active-low reset:
  clk  in  1  clock; all state updates on rising edge
  rst_n  in  1  synchronous active-low reset
  flush  in  1  discard held and incoming instruction
  in_valid  in  1  instr valid from fetch
  in_ready  out  1  stage can accept instr
  instr  in  32  RV32I instruction word
  out_valid  out  1  decoded bundle valid to execute stage
  out_ready  in  1  execute stage accepts bundle
  alu_ctrl  out  5  ALU op: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA
  alu_src_imm  out  1  1 = operand y is imm, 0 = rs2 value
  imm  out  32  sign-extended immediate (I/S/B/U format)
  rs1, rs2, rd  out  5 each  register indices
  reg_write  out  1  instruction writes rd
  illegal  out  1  unsupported encoding

Function
REQ-002 Decode SHALL be registered: accepted instr appears on outputs exactly 1 cycle after the in_valid&&in_ready edge.
REQ-003 Transfer in SHALL occur when in_valid&&in_ready; out SHALL occur when out_valid&&out_ready.
REQ-004 While out_valid&&!out_ready, all outputs SHALL remain stable.
REQ-005 Opcode 0x33: funct7 0x00 maps f3 0..7 to ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND; funct7 0x20 with f3 0/5 maps to SUB/SRA; any other funct7 SHALL set illegal.
REQ-006 Opcode 0x13: I-ALU mapping as above with ADD for f3 0; SLLI/SRLI require imm[11:5]=0, SRAI requires 0x20, else illegal; alu_src_imm=1.
REQ-007 Opcodes 0x03 (load), 0x23 (store) SHALL give ADD, alu_src_imm=1; store reg_write=0.
REQ-008 Opcode 0x63 with f3 0 (BEQ) or 1 (BNE) SHALL give SUB, alu_src_imm=0, reg_write=0; other f3 illegal.
REQ-009 Opcode 0x37 (LUI) SHALL give ADD, rs1 forced 0, imm={instr[31:12],12'b0}, alu_src_imm=1.
REQ-010 Any other opcode SHALL set illegal=1, alu_ctrl=0, reg_write=0; illegal bundles still handshake normally.
REQ-011 reg_write SHALL be 0 whenever rd=0.
REQ-012 flush SHALL clear out_valid next cycle, discard any simultaneous input transfer, and take priority over in_valid and out_ready.

Reset
REQ-013 With rst_n=0 at a clock edge, out_valid=0, in_ready=0 during reset, all data outputs=0, skid entry (if present) empty.
REQ-014 Reset mid-stall SHALL drop the held bundle; in_ready SHALL be 1 the cycle after rst_n rises.

Configuration
REQ-015 Macro ALU_DECODE_SKID_EN SHALL select buffering.
REQ-016 Without it: in_ready = !out_valid || out_ready (combinational path from out_ready).
REQ-017 With it: in_ready is a flop output, a one-entry skid buffer absorbs the instruction accepted during the cycle out_ready falls; full throughput at out_ready=1, no loss, order preserved; flush empties skid too.

Structure
REQ-018 Package alu_pkg SHALL hold the 5-bit ALU op codes and RV32I opcode/funct constants, shared with the ALU.
REQ-019 Immediate extraction SHALL be a combinational sub-module rv_imm_gen (instr in, format select in, imm out).

Verification
REQ-020 instr=0x00510093 (ADDI x1,x2,5) -> next cycle out_valid=1, alu_ctrl=2, imm=5, rs1=2, rd=1, alu_src_imm=1, reg_write=1.
REQ-021 instr=0x402081B3 (SUB x3,x1,x2) -> alu_ctrl=3, rs1=1, rs2=2, rd=3, alu_src_imm=0.
REQ-022 instr=0x40335293 (SRAI x5,x6,3) -> alu_ctrl=9, imm[4:0]=3; instr=0x00208463 (BEQ) -> alu_ctrl=3, reg_write=0, imm=8.
REQ-023 instr=0xFFFFFFFF -> illegal=1, alu_ctrl=0, reg_write=0.
REQ-024 Stream 4 instrs with out_ready toggling 1,0,0,1 -> all 4 delivered in order, outputs stable during stall; with ALU_DECODE_SKID_EN, zero lost beats.
REQ-025 flush asserted while out_valid=1 and in_valid=1 -> out_valid=0 next cycle, neither instr delivered.
